// File: rtl/kb_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
//   kb_state_t  : committed key state (released / pressed)
//   cand_kind_t : classification of one completed scan
//   cand_t      : scan candidate, kind plus key code (code is 0 unless kind is ONE)
//   kb_code()   : maps a (row, col) position to its key code
package kb_pkg;

   localparam int unsigned KB_ROWS    = 4;
   localparam int unsigned KB_COLS    = 4;
   localparam int unsigned KBCODE_WID = 5;

   typedef enum logic {
      S_REL,
      S_PRS
   } kb_state_t;

   typedef enum logic [1:0] {
      CAND_NONE,
      CAND_ONE,
      CAND_MULTI
   } cand_kind_t;

   typedef struct packed {
      cand_kind_t  kind;
      logic [3:0]  code;
   } cand_t;

   // Layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
   // with A-D = 10-13, * = 14, # = 15.
   function automatic logic [3:0] kb_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      unique case ({row, col})
         4'h0:    code = 4'd1;
         4'h1:    code = 4'd2;
         4'h2:    code = 4'd3;
         4'h3:    code = 4'd10;
         4'h4:    code = 4'd4;
         4'h5:    code = 4'd5;
         4'h6:    code = 4'd6;
         4'h7:    code = 4'd11;
         4'h8:    code = 4'd7;
         4'h9:    code = 4'd8;
         4'ha:    code = 4'd9;
         4'hb:    code = 4'd12;
         4'hc:    code = 4'd14;
         4'hd:    code = 4'd0;
         4'he:    code = 4'd15;
         default: code = 4'd13;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/kb_sync2.sv
// Two-flop synchroniser for asynchronous inputs.
//   clk : system clock
//   rst : synchronous active-high reset; both stages reset to all-ones (idle columns)
//   d   : asynchronous input bus
//   q   : synchronised output bus
module kb_sync2 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with synchroniser and scan-level debounce.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   col_in      : keypad columns, active-low, asynchronous
//   row_out     : keypad row drive, active-low, one row low at a time
//   kb_idx      : [4] key held, [3:0] last committed key code
//   key_pressed : one-cycle pulse for every newly committed key
module keypad_scanner
   import kb_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50_000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [KB_COLS-1:0]    col_in,
   output logic [KB_ROWS-1:0]    row_out,
   output logic [KBCODE_WID-1:0] kb_idx,
   output logic                  key_pressed
);

   localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned STAB_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

   logic [KB_COLS-1:0]         w_col_s;
   logic [DIV_W-1:0]           r_div_cnt;
   logic [1:0]                 r_row_sel;
   logic [KB_ROWS*KB_COLS-1:0] r_keymap;
   cand_t                      r_last_cand;
   logic [STAB_W-1:0]          r_stab_cnt;
   kb_state_t                  r_state;
   logic [KBCODE_WID-1:0]      r_kb_idx;
   logic                       r_key_pressed;

   logic                       w_wrap;
   logic                       w_scan_end;
   logic [KB_ROWS*KB_COLS-1:0] w_map_next;
   cand_t                      w_cand;
   logic                       w_same;
   logic [STAB_W-1:0]          w_stab_d;
   logic                       w_stable;

   kb_sync2 #(
      .WIDTH (KB_COLS)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (col_in),
      .q   (w_col_s)
   );

   assign w_wrap     = (r_div_cnt == DIV_LAST);
   assign w_scan_end = w_wrap && (r_row_sel == 2'd3);

   // Map as it will look after this cycle's sample, so the row-3 sample is
   // classified in the same cycle it is taken.
   always_comb begin
      w_map_next = r_keymap;
      w_map_next[r_row_sel*KB_COLS +: KB_COLS] = ~w_col_s;
   end

   always_comb begin
      logic [4:0] n_set;
      n_set       = '0;
      w_cand.kind = CAND_NONE;
      w_cand.code = 4'd0;
      for (int r = 0; r < KB_ROWS; r++) begin
         for (int c = 0; c < KB_COLS; c++) begin
            if (w_map_next[r*KB_COLS + c]) begin
               n_set       = n_set + 5'd1;
               w_cand.code = kb_code(2'(r), 2'(c));
            end
         end
      end
      if (n_set == 5'd1) begin
         w_cand.kind = CAND_ONE;
      end else if (n_set > 5'd1) begin
         w_cand.kind = CAND_MULTI;
         w_cand.code = 4'd0;
      end else begin
         w_cand.code = 4'd0;
      end
   end

   assign w_same = (w_cand == r_last_cand);

   always_comb begin
      w_stab_d = r_stab_cnt;
      if (w_cand.kind == CAND_MULTI) begin
         w_stab_d = '0;
      end else if (w_same) begin
         if (r_stab_cnt < STAB_MAX) begin
            w_stab_d = r_stab_cnt + STAB_W'(1);
         end
      end else begin
         w_stab_d = STAB_W'(1);
      end
   end

   assign w_stable = (w_cand.kind != CAND_MULTI) && (w_stab_d == STAB_MAX);

   // Row timer, sampling and debounce state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt   <= '0;
         r_row_sel   <= 2'd0;
         r_keymap    <= '0;
         r_last_cand <= '{kind: CAND_NONE, code: 4'd0};
         r_stab_cnt  <= '0;
      end else if (w_wrap) begin
         r_div_cnt <= '0;
         r_row_sel <= r_row_sel + 2'd1;
         r_keymap  <= w_map_next;
         if (w_scan_end) begin
            r_stab_cnt <= w_stab_d;
            if ((w_cand.kind != CAND_MULTI) && !w_same) begin
               r_last_cand <= w_cand;
            end
         end
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   // Commit FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_REL;
         r_kb_idx      <= '0;
         r_key_pressed <= 1'b0;
      end else begin
         r_key_pressed <= 1'b0;
         if (w_scan_end && w_stable) begin
            unique case (r_state)
               S_REL: begin
                  if (w_cand.kind == CAND_ONE) begin
                     r_state       <= S_PRS;
                     r_kb_idx      <= {1'b1, w_cand.code};
                     r_key_pressed <= 1'b1;
                  end
               end
               S_PRS: begin
                  if (w_cand.kind == CAND_NONE) begin
                     r_state     <= S_REL;
                     r_kb_idx[4] <= 1'b0;
                  end else if (w_cand.code != r_kb_idx[3:0]) begin
                     r_kb_idx      <= {1'b1, w_cand.code};
                     r_key_pressed <= 1'b1;
                  end
               end
               default: r_state <= S_REL;
            endcase
         end
      end
   end

   assign row_out     = ~(4'b0001 << r_row_sel);
   assign kb_idx      = r_kb_idx;
   assign key_pressed = r_key_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scan).
module tb_keypad_scanner;

   logic       clk;
   logic       rst;
   logic [3:0] col_in;
   logic [3:0] row_out;
   logic [4:0] kb_idx;
   logic       key_pressed;

   logic [15:0] keys;     // bit r*4+c = key at row r, col c held
   logic        tog_en;
   logic [3:0]  tog_val;
   logic        x_chk_en;

   int n_total;
   int n_bad;
   int pulses;
   int wide_cnt;
   int x_cnt;
   logic prev_kp;

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .col_in      (col_in),
      .row_out     (row_out),
      .kb_idx      (kb_idx),
      .key_pressed (key_pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a held key pulls its column low while its row is driven.
   always_comb begin
      logic [3:0] w;
      w = 4'hf;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4 + c] && !row_out[r]) w[c] = 1'b0;
         end
      end
      col_in = tog_en ? tog_val : w;
   end

   always @(negedge clk) begin
      if (key_pressed === 1'b1) begin
         pulses <= pulses + 1;
         if (prev_kp === 1'b1) wide_cnt <= wide_cnt + 1;
      end
      prev_kp <= key_pressed;
      if (x_chk_en && $isunknown({row_out, kb_idx, key_pressed})) x_cnt <= x_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at the negedge right after the reset edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int p0;

   initial begin
      rst = 1'b0; keys = '0; tog_en = 1'b0; tog_val = 4'hf; x_chk_en = 1'b0;
      n_total = 0; n_bad = 0; pulses = 0; wide_cnt = 0; x_cnt = 0; prev_kp = 1'b0;

      // 1: hold '6' (r1c2) from reset; commit after two scans
      keys = 16'h0040;
      do_reset();
      p0 = pulses;
      check("t1_rst_row",   32'(row_out), 32'hE);
      check("t1_rst_idx",   32'(kb_idx), 32'h00);
      check("t1_rst_kp",    32'(key_pressed), 32'h0);
      tick(31);
      check("t1_pre_idx",   32'(kb_idx), 32'h00);
      tick(1);
      check("t1_idx",       32'(kb_idx), 32'h16);
      check("t1_kp",        32'(key_pressed), 32'h1);
      tick(3);
      check("t1_pulses",    32'(pulses - p0), 32'd1);
      tick(640);
      check("t1_hold_idx",  32'(kb_idx), 32'h16);
      check("t1_hold_puls", 32'(pulses - p0), 32'd1);

      // 2: '0' (r3c1) for one scan only is rejected
      keys = 16'h2000;
      do_reset();
      p0 = pulses;
      tick(16);
      keys = '0;
      tick(96);
      check("t2_idx",       32'(kb_idx), 32'h00);
      check("t2_pulses",    32'(pulses - p0), 32'd0);

      // 3: '6' -> 'A' (r0c3) -> release
      keys = 16'h0040;
      do_reset();
      tick(34);
      check("t3_six",       32'(kb_idx), 32'h16);
      p0 = pulses;
      keys = 16'h0008;
      tick(64);
      check("t3_a_idx",     32'(kb_idx), 32'h1A);
      check("t3_a_pulses",  32'(pulses - p0), 32'd1);
      p0 = pulses;
      keys = '0;
      tick(64);
      check("t3_rel_idx",   32'(kb_idx), 32'h0A);
      check("t3_rel_puls",  32'(pulses - p0), 32'd0);

      // 4: '5' then two keys together (r0c0 + r2c2) is ignored
      keys = 16'h0020;
      do_reset();
      tick(34);
      check("t4_five",      32'(kb_idx), 32'h15);
      p0 = pulses;
      keys = 16'h0401;
      tick(80);
      check("t4_multi_idx", 32'(kb_idx), 32'h15);
      check("t4_multi_pls", 32'(pulses - p0), 32'd0);
      keys = '0;
      tick(64);
      check("t4_rel_idx",   32'(kb_idx), 32'h05);
      check("t4_rel_puls",  32'(pulses - p0), 32'd0);

      // 5: reset mid row-2 dwell while '#' (r3c2) stabilises
      do_reset();
      keys = 16'h4000;
      tick(26);
      check("t5_mid_row",   32'(row_out), 32'hB);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_rst_row",   32'(row_out), 32'hE);
      check("t5_rst_idx",   32'(kb_idx), 32'h00);
      check("t5_rst_kp",    32'(key_pressed), 32'h0);
      tick(31);
      check("t5_pre_idx",   32'(kb_idx), 32'h00);
      tick(1);
      check("t5_idx",       32'(kb_idx), 32'h1F);
      check("t5_kp",        32'(key_pressed), 32'h1);
      tick(1);
      check("t5_kp_off",    32'(key_pressed), 32'h0);

      // 6: asynchronous column toggling
      keys = '0;
      do_reset();
      x_chk_en = 1'b1;
      tog_val  = 4'hf;
      tog_en   = 1'b1;
      #3;
      for (int i = 0; i < 67; i++) begin
         #30 tog_val = {tog_val[2:0], ~tog_val[3]};
      end
      tog_en = 1'b0;
      tick(40);
      x_chk_en = 1'b0;
      check("t6_no_x",      32'(x_cnt), 32'd0);
      check("pulse_width",  32'(wide_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
